steer_gear_sched: RTL
=====================

Name: steer_gear_sched

Overview:
- Converts each of the four players' digital controls (left/right, gear-up/gear-down buttons) into Sprint4-style steering quadrature and a 4-position gear shifter state.
- One shared step engine updates all four players round-robin, one player per cycle, after each prescaler tick.
- Sits between the arcade input decoder and the sprint4 core's steering/gear inputs, in the clk_12 domain.

Parameters:
- STEP_DIV, 12096, clk_12 cycles between steering step ticks (about 1 ms). Legal range is 8 to 2^DIV_W-1.
- DIV_W, 16, width of the prescaler counter.

Ports:
- clk_12  in  1  system clock, 12.096 MHz.
- Reset_I  in  1  asynchronous, active-low reset.
- en_i  in  1  when low, freezes steering phases and gear updates. Synchronizers and the prescaler keep running.
- left_i  in  4  left held, bit n = player n, active high, asynchronous.
- right_i  in  4  right held, bit n = player n, active high, asynchronous.
- gup_i  in  4  gear-up button, active high, asynchronous.
- gdn_i  in  4  gear-down button, active high, asynchronous.
- steer_a_o  out  4  quadrature phase A per player.
- steer_b_o  out  4  quadrature phase B per player.
- gear_o  out  8  per player 2-bit gear, bits [2n+1:2n]; 0 = 1st gear, 3 = 4th gear.
- gear_oh_o  out  16  per player one-hot gear, bits [4n+3:4n]; bit k = gear k+1. Direct decode of gear_o.
- busy_o  out  1  high while any player's step is still pending in the current tick.

Behaviour:

Reset:
- Reset_I low asynchronously clears all state.
- Reset values: prescaler 0, pending 4'b0000, phase[n] 0, gear[n] 0, synchronizers 0, edge registers 0.
- Outputs after reset: steer_a_o=0, steer_b_o=0, gear_o=0, gear_oh_o=16'h1111, busy_o=0.
- Reset asserted mid-sequence aborts all pending steps; no partial update survives.

Input synchronization:
- All 16 input bits pass through a 2-flop synchronizer.
- Gear edge detection uses a third registered copy.
- A rising edge is detected 3 cycles after the input rises.

Prescaler:
- Counts 0 to STEP_DIV-1, then wraps.
- On the wrap cycle it asserts tick for one cycle.
- tick sets pending to 4'b1111 on the next edge.

Scheduler (per cycle):
- If pending is nonzero, service the lowest set index n and clear pending[n].
- Player n is therefore updated n+1 cycles after the tick. Player 3's update completes 4 cycles after the tick.
- busy_o = |pending.
- STEP_DIV >= 8 guarantees pending is empty before the next tick. If a tick coincides with nonzero pending anyway (illegal parameter), pending is OR-set to 1111 and no step is lost or duplicated beyond one per tick.

Service of player n (en_i high):
- right only: phase[n] += 1, mod 4.
- left only: phase[n] -= 1, mod 4.
- both or neither: phase[n] unchanged.
- steer_a_o[n] = phase[n][1].
- steer_b_o[n] = phase[n][1] ^ phase[n][0].
- Right rotation yields the AB sequence 00, 01, 11, 10, 00. Left rotation is the reverse.
- Phase wrap-around is continuous; there is no end stop.
- en_i low during service: pending[n] is cleared and the phase is unchanged.

Gear (evaluated every cycle, independent of the scheduler, gated by en_i):
- Rising edge on gup with no gdn edge: gear += 1, saturating at 3.
- Rising edge on gdn with no gup edge: gear -= 1, saturating at 0.
- Simultaneous up and down edges in the same cycle: no change.
- Holding a button produces exactly one step.
- Edges that occur while en_i is low are discarded, not queued.

Output timing:
- All outputs are registered except gear_oh_o, which is a combinational decode of registered gear state.

Test Plan:
- Reset behaviour: hold Reset_I=0, toggle all inputs. Then release. -> All outputs at reset values throughout; busy_o=0; first tick occurs after exactly STEP_DIV cycles.
- Right steering: STEP_DIV=8, right_i=4'b0001 held for 5 ticks. -> Player 0 AB sequence 01, 11, 10, 00, 01, each change 1 cycle after its tick. Players 1-3 stay at 00.
- Round-robin latency: left_i=4'b1111 across one tick. -> Players 0, 1, 2, 3 each change to AB=10, on cycles tick+1, +2, +3, +4 respectively. busy_o is high for exactly 4 cycles.
- Conflicting steering inputs: left_i[2]=right_i[2]=1 for 10 ticks. -> Player 2 phase unchanged; no glitch on steer_a_o[2] or steer_b_o[2].
- Gear saturation: pulse gup_i[1] 5 times. -> gear_o[3:2] goes 1, 2, 3, 3, 3 and gear_oh_o[7:4]=4'b1000. Then pulse gdn_i[1] 4 times -> gear 2, 1, 0, 0.
- Simultaneous edges and freeze: raise gup_i[3] and gdn_i[3] on the same cycle -> gear unchanged. With en_i=0, pulse gup_i[0] and hold right_i[0] across 3 ticks -> no phase or gear change. After en_i returns to 1, the next tick steps player 0.

Source files
------------

// File: rtl/steer_gear_sched.sv
// steer_gear_sched: converts four players' digital left/right and gear
// buttons into Sprint4-style steering quadrature plus a 4-position gear.
// A single step engine walks the players round-robin after each prescaler
// tick. Gear shifts are edge-driven and are evaluated on every cycle.
module steer_gear_sched #(
   parameter int STEP_DIV = 12096,
   parameter int DIV_W    = 16
) (
   input  logic        clk_12,
   input  logic        Reset_I,
   input  logic        en_i,
   input  logic [3:0]  left_i,
   input  logic [3:0]  right_i,
   input  logic [3:0]  gup_i,
   input  logic [3:0]  gdn_i,
   output logic [3:0]  steer_a_o,
   output logic [3:0]  steer_b_o,
   output logic [7:0]  gear_o,
   output logic [15:0] gear_oh_o,
   output logic        busy_o
);

   logic [15:0]          sync1_q, sync2_q;
   logic [7:0]           gedge_q;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [3:0]           pend_q, pend_d, svc;
   logic                 busy_q, busy_d, tick;
   logic [3:0]           a_q, a_d, b_q, b_d;
   logic [3:0][1:0]      gear_q, gear_d;
   logic [3:0]           lft, rgt, gu, gd, up_edge, dn_edge;

   assign lft     = sync2_q[3:0];
   assign rgt     = sync2_q[7:4];
   assign gu      = sync2_q[11:8];
   assign gd      = sync2_q[15:12];
   // The third registered copy exists only for the gear buttons.
   assign up_edge = gu & ~gedge_q[3:0];
   assign dn_edge = gd & ~gedge_q[7:4];

   assign tick    = (div_q == DIV_W'(STEP_DIV - 1));

   // Prescaler wrap and round-robin pick of the lowest pending player.
   always_comb begin
      div_d  = tick ? '0 : div_q + 1'b1;
      svc    = pend_q & (~pend_q + 4'd1);
      // A tick landing on leftover work simply re-arms every player.
      pend_d = (pend_q & ~svc) | {4{tick}};
      busy_d = |pend_d;
   end

   // Steering phase step for the serviced player, and per-player gear shifts.
   always_comb begin
      logic [1:0] ph, ph_nx;
      a_d    = a_q;
      b_d    = b_q;
      gear_d = gear_q;
      ph     = 2'd0;
      ph_nx  = 2'd0;
      for (int n = 0; n < 4; n++) begin
         // The phase is held as its A/B encoding so both outputs are flops.
         ph    = {a_q[n], a_q[n] ^ b_q[n]};
         ph_nx = ph;
         if (svc[n] && en_i) begin
            if (rgt[n] && !lft[n])      ph_nx = ph + 2'd1;
            else if (lft[n] && !rgt[n]) ph_nx = ph - 2'd1;
         end
         a_d[n] = ph_nx[1];
         b_d[n] = ph_nx[1] ^ ph_nx[0];
         if (en_i) begin
            if (up_edge[n] && !dn_edge[n] && gear_q[n] != 2'd3)
               gear_d[n] = gear_q[n] + 2'd1;
            else if (dn_edge[n] && !up_edge[n] && gear_q[n] != 2'd0)
               gear_d[n] = gear_q[n] - 2'd1;
         end
      end
   end

   // One-hot gear decode straight from the gear registers.
   always_comb begin
      gear_oh_o = '0;
      for (int n = 0; n < 4; n++)
         gear_oh_o[4*n +: 4] = 4'b0001 << gear_q[n];
   end

   // All state registers; reset clears everything, including pending steps.
   always_ff @(posedge clk_12 or negedge Reset_I) begin
      if (!Reset_I) begin
         sync1_q <= '0;
         sync2_q <= '0;
         gedge_q <= '0;
         div_q   <= '0;
         pend_q  <= '0;
         busy_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         gear_q  <= '0;
      end else begin
         sync1_q <= {gdn_i, gup_i, right_i, left_i};
         sync2_q <= sync1_q;
         gedge_q <= sync2_q[15:8];
         div_q   <= div_d;
         pend_q  <= pend_d;
         busy_q  <= busy_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gear_q  <= gear_d;
      end
   end

   assign steer_a_o = a_q;
   assign steer_b_o = b_q;
   assign gear_o    = gear_q;
   assign busy_o    = busy_q;

endmodule
